lc3b_l1_cache: RTL and testbench
================================

# lc3b_l1_cache

Direct-mapped, write-back, write-allocate L1 cache between the LC-3b datapath memory port and physical memory. Eight 128-bit lines, each with a tag, a valid bit and a dirty bit. Serves 16-bit word reads and byte-masked writes from the CPU. Misses are satisfied with whole-line transfers on the 128-bit physical memory bus, with a writeback of the victim line first when that line is dirty.

## Interface
Parameters: none; geometry fixed by lc3b_c_tag (9), lc3b_c_index (3), lc3b_c_offset (4).
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- mem_address  in  16  CPU byte address (lc3b_word); tag [15:7], index [6:4], offset [3:0]; offset[3:1] selects word, offset[0] ignored
- mem_read  in  1  CPU read request, held until mem_resp
- mem_write  in  1  CPU write request, held until mem_resp
- mem_byte_enable  in  2  lc3b_mem_wmask; [1] high byte, [0] low byte
- mem_wdata  in  16  CPU write data
- mem_rdata  out  16  read word; 16'h0000 whenever mem_resp=0
- mem_resp  out  1  one-cycle completion pulse
- pmem_address  out  16  line address, offset bits always 4'b0000
- pmem_read  out  1  line fill request, held until pmem_resp
- pmem_write  out  1  line writeback request, held until pmem_resp
- pmem_wdata  out  128  victim line data (lc3b_mem_data)
- pmem_rdata  in  128  fill data, valid in the pmem_resp cycle
- pmem_resp  in  1  physical memory completion, one cycle

## Operation
- States: IDLE, WRITEBACK, FILL.
- IDLE, no request: all outputs 0.
- IDLE, request with a hit (valid[index] and tag match): mem_resp=1 in the same cycle.
  - Read: mem_rdata = line word offset[3:1].
  - Write: masked bytes merge into the line at the clock edge and dirty[index] is set. A mask of 2'b00 still responds and sets dirty.
- IDLE, miss with line invalid or clean: go to FILL.
- IDLE, miss with line valid and dirty: go to WRITEBACK.
- WRITEBACK: pmem_write=1, pmem_address={stored tag, index, 4'b0}, pmem_wdata=line. On pmem_resp, clear dirty and go to FILL.
- FILL: pmem_read=1, pmem_address={mem_address tag, index, 4'b0}. On pmem_resp, store pmem_rdata, store tag, set valid, clear dirty, go to IDLE. The request then hits on the next cycle.
- pmem_wdata is 0 outside WRITEBACK. pmem_address is 0 in IDLE.
- mem_read and mem_write both high: treated as a write.
- Request deasserted during WRITEBACK/FILL: the transfer completes, the line is installed, and no mem_resp is issued.
- The CPU must hold mem_address stable during a miss. Tag and index are sampled combinationally, not latched.

## Timing
- Hit: 0 extra cycles; mem_resp in the request cycle.
- Clean miss: FILL is entered on the next edge. Response comes 1 cycle after pmem_resp.
- Dirty miss: writeback latency, then fill latency, then 1 cycle.
- pmem_read and pmem_write are never high together. Each is held continuously until pmem_resp.
- Reset (asynchronous, at any time including mid-transfer): state=IDLE; all valid and dirty bits cleared; mem_resp, pmem_read and pmem_write drop to 0 immediately. Data and tag arrays are not reset.
- mem_resp never asserts in WRITEBACK or FILL.

## Test plan
- Cold read: after reset, read 16'h0012 with memory returning a line whose word 1 is 16'hBEEF. Required: pmem_read with pmem_address 16'h0010; then mem_resp with mem_rdata 16'hBEEF; a repeat read hits with 0 pmem activity.
- Byte write hit: with line 16'h0010 resident, write 16'hAB12 to 16'h0014 with mask 2'b01. Required: a read of 16'h0014 returns the old high byte with low byte 8'h12; dirty[1]=1.
- Dirty eviction: after the write above, read 16'h0094 (same index, tag 1). Required: pmem_write at 16'h0010 carrying the modified line, then pmem_read at 16'h0090, then mem_resp.
- Clean eviction: evict a clean line. Required: no pmem_write, only pmem_read.
- Reset mid-FILL: assert reset_n=0 while pmem_read=1. Required: pmem_read falls without waiting for a clock; a previously resident address then misses.
- Dropped request: deassert mem_read during FILL. Required: the line is installed and mem_resp stays 0; a later read of that address hits.

Source files
------------

// File: rtl/lc3b_l1_cache.sv
// Direct-mapped, write-back, write-allocate L1 cache for the LC-3b memory port.
// Eight 128-bit lines; misses move whole lines over the physical memory bus.
module lc3b_l1_cache (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [15:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [1:0]   mem_byte_enable,
  input  logic [15:0]  mem_wdata,
  output logic [15:0]  mem_rdata,
  output logic         mem_resp,
  output logic [15:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);

  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;

  state_t       state_q, state_d;
  logic [127:0] data_q [8];
  logic [127:0] data_d [8];
  logic [8:0]   tag_q [8];
  logic [8:0]   tag_d [8];
  logic [7:0]   valid_q, valid_d;
  logic [7:0]   dirty_q, dirty_d;

  logic [8:0]   addr_tag;
  logic [2:0]   addr_idx;
  logic [2:0]   word_sel;
  logic [6:0]   lo_base;
  logic [6:0]   hi_base;
  logic [127:0] line;
  logic [127:0] merged;
  logic         hit;
  logic         req;
  logic         unused_addr_bit;

  assign addr_tag        = mem_address[15:7];
  assign addr_idx        = mem_address[6:4];
  assign word_sel        = mem_address[3:1];
  assign unused_addr_bit = mem_address[0];
  assign lo_base         = {word_sel, 4'b0000};
  assign hi_base         = {word_sel, 4'b1000};
  assign line            = data_q[addr_idx];
  assign hit             = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);
  assign req             = mem_read || mem_write;

  // A simultaneous read and write is served as a write.
  always_comb begin
    merged = line;
    if (mem_byte_enable[0]) merged[lo_base +: 8] = mem_wdata[7:0];
    if (mem_byte_enable[1]) merged[hi_base +: 8] = mem_wdata[15:8];
  end

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    tag_d        = tag_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    mem_rdata    = 16'h0000;
    mem_resp     = 1'b0;
    pmem_address = 16'h0000;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_wdata   = '0;

    case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            mem_resp = 1'b1;
            if (mem_write) begin
              data_d[addr_idx]  = merged;
              dirty_d[addr_idx] = 1'b1;
            end else begin
              mem_rdata = line[lo_base +: 16];
            end
          end else if (valid_q[addr_idx] && dirty_q[addr_idx]) begin
            state_d = WRITEBACK;
          end else begin
            state_d = FILL;
          end
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q[addr_idx], addr_idx, 4'b0000};
        pmem_wdata   = line;
        if (pmem_resp) begin
          dirty_d[addr_idx] = 1'b0;
          state_d           = FILL;
        end
      end
      FILL: begin
        // Completes even if the CPU dropped its request; the line stays installed.
        pmem_read    = 1'b1;
        pmem_address = {addr_tag, addr_idx, 4'b0000};
        if (pmem_resp) begin
          data_d[addr_idx]  = pmem_rdata;
          tag_d[addr_idx]   = addr_tag;
          valid_d[addr_idx] = 1'b1;
          dirty_d[addr_idx] = 1'b0;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Line data and tags carry no reset; valid bits guard them.
  always_ff @(posedge clk) begin
    data_q <= data_d;
    tag_q  <= tag_d;
  end

endmodule

// File: tb/tb_lc3b_l1_cache.sv
// Directed bench for lc3b_l1_cache with a two-cycle-latency physical memory model.
module tb_lc3b_l1_cache;

  logic         clk;
  logic         reset_n;
  logic [15:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_wdata;
  logic [15:0]  mem_rdata;
  logic         mem_resp;
  logic [15:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  logic [127:0] pmem [4096];
  logic         auto_resp;
  int           rd_cnt, wr_cnt;
  logic [15:0]  last_rd_addr, last_wr_addr;
  logic [127:0] last_wr_data;
  int           n_tests, n_fail;

  lc3b_l1_cache dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .pmem_address    (pmem_address),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] init_line(input logic [11:0] l);
    logic [127:0] r;
    for (int k = 0; k < 8; k++) r[k*16 +: 16] = {4'(k), l};
    return r;
  endfunction

  // Physical memory: responds on the second edge after a request is seen.
  initial begin
    int lat;
    lat        = 0;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (pmem_resp) begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        lat        = 0;
      end else if (auto_resp && (pmem_read || pmem_write)) begin
        lat++;
        if (lat == 2) begin
          if (pmem_write) begin
            wr_cnt++;
            last_wr_addr             = pmem_address;
            last_wr_data             = pmem_wdata;
            pmem[pmem_address[15:4]] = pmem_wdata;
          end else begin
            rd_cnt++;
            last_rd_addr = pmem_address;
            pmem_rdata   = pmem[pmem_address[15:4]];
          end
          pmem_resp = 1'b1;
        end
      end else begin
        lat = 0;
      end
    end
  end

  task automatic cpu_access(input logic rd, input logic wr, input logic [15:0] addr,
                            input logic [1:0] be, input logic [15:0] wd,
                            output logic [15:0] rdata, output int cyc);
    mem_address     = addr;
    mem_read        = rd;
    mem_write       = wr;
    mem_byte_enable = be;
    mem_wdata       = wd;
    cyc             = 0;
    #1;
    while (!mem_resp && cyc < 40) begin
      chk("pmem_excl", 128'(pmem_read & pmem_write), 128'(0));
      @(posedge clk);
      #3;
      cyc++;
    end
    chk("resp_seen", 128'(mem_resp), 128'(1));
    rdata = mem_rdata;
    @(posedge clk);
    #2;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  initial begin
    logic [15:0]  rd;
    logic [127:0] exp_line;
    int           cyc, rd0, wr0;
    logic         saw_resp;

    n_tests = 0; n_fail = 0; rd_cnt = 0; wr_cnt = 0;
    last_rd_addr = '0; last_wr_addr = '0; last_wr_data = '0;
    auto_resp = 1'b1;
    for (int i = 0; i < 4096; i++) pmem[i] = init_line(12'(i));
    exp_line = pmem[1];
    exp_line[31:16] = 16'hBEEF;
    pmem[1] = exp_line;

    reset_n = 1'b0; mem_address = '0; mem_read = 1'b0; mem_write = 1'b0;
    mem_byte_enable = '0; mem_wdata = '0;
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    #1;
    chk("rst_resp",   128'(mem_resp), 128'(0));
    chk("rst_rdata",  128'(mem_rdata), 128'(0));
    chk("rst_pread",  128'(pmem_read), 128'(0));
    chk("rst_pwrite", 128'(pmem_write), 128'(0));
    chk("rst_paddr",  128'(pmem_address), 128'(0));
    chk("rst_pwdata", pmem_wdata, 128'(0));
    @(posedge clk); #2;

    // Cold read
    rd0 = rd_cnt; wr0 = wr_cnt;
    cpu_access(1'b1, 1'b0, 16'h0012, 2'b00, 16'h0000, rd, cyc);
    chk("cold_rdata", 128'(rd), 128'(16'hBEEF));
    chk("cold_paddr", 128'(last_rd_addr), 128'(16'h0010));
    chk("cold_nrd",   128'(rd_cnt - rd0), 128'(1));
    chk("cold_nwr",   128'(wr_cnt - wr0), 128'(0));

    rd0 = rd_cnt;
    cpu_access(1'b1, 1'b0, 16'h0012, 2'b00, 16'h0000, rd, cyc);
    chk("hit_rdata", 128'(rd), 128'(16'hBEEF));
    chk("hit_cyc",   128'(cyc), 128'(0));
    chk("hit_nrd",   128'(rd_cnt - rd0), 128'(0));

    // Byte write hit, low byte only
    cpu_access(1'b0, 1'b1, 16'h0014, 2'b01, 16'hAB12, rd, cyc);
    chk("bw_cyc", 128'(cyc), 128'(0));
    cpu_access(1'b1, 1'b0, 16'h0014, 2'b00, 16'h0000, rd, cyc);
    chk("bw_rdata", 128'(rd), 128'(16'h2012));

    // Dirty eviction
    rd0 = rd_cnt; wr0 = wr_cnt;
    exp_line[47:32] = 16'h2012;
    cpu_access(1'b1, 1'b0, 16'h0094, 2'b00, 16'h0000, rd, cyc);
    chk("de_waddr", 128'(last_wr_addr), 128'(16'h0010));
    chk("de_wdata", last_wr_data, exp_line);
    chk("de_raddr", 128'(last_rd_addr), 128'(16'h0090));
    chk("de_nwr",   128'(wr_cnt - wr0), 128'(1));
    chk("de_nrd",   128'(rd_cnt - rd0), 128'(1));
    chk("de_rdata", 128'(rd), 128'(16'h2009));

    // Clean eviction
    rd0 = rd_cnt; wr0 = wr_cnt;
    cpu_access(1'b1, 1'b0, 16'h0012, 2'b00, 16'h0000, rd, cyc);
    chk("ce_nwr",   128'(wr_cnt - wr0), 128'(0));
    chk("ce_nrd",   128'(rd_cnt - rd0), 128'(1));
    chk("ce_rdata", 128'(rd), 128'(16'hBEEF));

    // Read and write together act as a write; high byte only
    cpu_access(1'b1, 1'b1, 16'h0012, 2'b10, 16'h5500, rd, cyc);
    cpu_access(1'b1, 1'b0, 16'h0012, 2'b00, 16'h0000, rd, cyc);
    chk("rw_rdata", 128'(rd), 128'(16'h55EF));

    // Empty mask still dirties the line
    cpu_access(1'b0, 1'b1, 16'h0020, 2'b00, 16'hFFFF, rd, cyc);
    rd0 = rd_cnt; wr0 = wr_cnt;
    cpu_access(1'b1, 1'b0, 16'h00A0, 2'b00, 16'h0000, rd, cyc);
    chk("m0_nwr",   128'(wr_cnt - wr0), 128'(1));
    chk("m0_waddr", 128'(last_wr_addr), 128'(16'h0020));
    chk("m0_wdata", last_wr_data, init_line(12'h002));
    chk("m0_rdata", 128'(rd), 128'(16'h000A));

    // Reset in the middle of a fill
    auto_resp = 1'b0;
    mem_address = 16'h0030; mem_read = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    chk("mf_pread", 128'(pmem_read), 128'(1));
    chk("mf_paddr", 128'(pmem_address), 128'(16'h0030));
    reset_n = 1'b0;
    #1;
    chk("mf_async_pread", 128'(pmem_read), 128'(0));
    mem_read = 1'b0;
    @(posedge clk); #2;
    reset_n = 1'b1;
    auto_resp = 1'b1;
    rd0 = rd_cnt; wr0 = wr_cnt;
    cpu_access(1'b1, 1'b0, 16'h0012, 2'b00, 16'h0000, rd, cyc);
    chk("mf_miss_nrd", 128'(rd_cnt - rd0), 128'(1));
    chk("mf_miss_nwr", 128'(wr_cnt - wr0), 128'(0));
    chk("mf_rdata",    128'(rd), 128'(16'hBEEF));

    // Request dropped during fill
    rd0 = rd_cnt;
    mem_address = 16'h0040; mem_read = 1'b1;
    cyc = 0;
    #1;
    while (!pmem_read && cyc < 10) begin
      @(posedge clk); #3; cyc++;
    end
    chk("dr_pread", 128'(pmem_read), 128'(1));
    mem_read = 1'b0;
    saw_resp = 1'b0;
    repeat (6) begin
      @(posedge clk); #3;
      saw_resp = saw_resp | mem_resp | (|mem_rdata);
    end
    chk("dr_no_resp", 128'(saw_resp), 128'(0));
    chk("dr_nrd", 128'(rd_cnt - rd0), 128'(1));
    cpu_access(1'b1, 1'b0, 16'h0040, 2'b00, 16'h0000, rd, cyc);
    chk("dr_hit_cyc",   128'(cyc), 128'(0));
    chk("dr_hit_rdata", 128'(rd), 128'(16'h0004));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
